// File: rtl/mmcm_drp_pkg.sv
// Shared types for the MMCM DRP reconfiguration initiator: sequencer states,
// table entry layout and DRP bus widths.
package mmcm_drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;
    localparam int TBL_IDX_W  = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ASSERT_RST,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_VFY_REQ,
        ST_VFY_WAIT,
        ST_NEXT,
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_FAULT
    } state_e;

    typedef struct packed {
        logic [DRP_ADDR_W-1:0] addr;
        logic [DRP_DATA_W-1:0] mask;
        logic [DRP_DATA_W-1:0] data;
    } drp_entry_t;

    // Mask bits set to 1 keep the readback value; 0 bits take the table data.
    function automatic logic [DRP_DATA_W-1:0] drp_merge(input drp_entry_t e,
                                                        input logic [DRP_DATA_W-1:0] rdata);
        return (rdata & e.mask) | (e.data & ~e.mask);
    endfunction

endpackage

// File: rtl/mmcm_drp_reconfig_if.sv
// DRP bus between the reconfiguration initiator (master) and the MMCME2_ADV
// DRP pins (slave).
interface mmcm_drp_reconfig_if;
    import mmcm_drp_pkg::*;

    logic [DRP_ADDR_W-1:0] drp_daddr;
    logic                  drp_den;
    logic                  drp_dwe;
    logic [DRP_DATA_W-1:0] drp_di;
    logic [DRP_DATA_W-1:0] drp_do;
    logic                  drp_drdy;

    modport master (
        output drp_daddr, drp_den, drp_dwe, drp_di,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_daddr, drp_den, drp_dwe, drp_di,
        output drp_do, drp_drdy
    );

endinterface

// File: rtl/mmcm_drp_reconfig_access.sv
// Single DRP transaction engine: turns a one-cycle req into a DEN/DWE pulse,
// then waits for DRDY with a bounded timeout.
module drp_access
    import mmcm_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [DRP_ADDR_W-1:0] addr,
    input  logic [DRP_DATA_W-1:0] wdata,
    mmcm_drp_reconfig_if.master   drp,
    output logic [DRP_DATA_W-1:0] rdata,
    output logic                  ack,
    output logic                  timeout
);

    localparam int CNT_W = $clog2(DRDY_TIMEOUT + 1);

    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // DRDY only counts while a transaction is pending; stray DRDY is ignored.
    always_comb begin
        drp.drp_den   = req;
        drp.drp_dwe   = req & we;
        drp.drp_daddr = req ? addr : '0;
        drp.drp_di    = (req && we) ? wdata : '0;
        rdata         = drp.drp_do;
        ack           = pend_q & drp.drp_drdy;
        timeout       = pend_q & ~drp.drp_drdy & (cnt_q == CNT_W'(DRDY_TIMEOUT - 1));
        pend_d        = pend_q;
        cnt_d         = cnt_q;
        if (req) begin
            pend_d = 1'b1;
            cnt_d  = '0;
        end else if (ack || timeout) begin
            pend_d = 1'b0;
        end else if (pend_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// Run-time MMCM reprogrammer: read-modify-write of a register table over DRP
// under MMCM reset, then lock wait. MMCM_DRP_VERIFY_EN adds a readback check.
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int RST_HOLD     = 8,
    parameter int LOCK_TIMEOUT = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TBL_IDX_W-1:0]  num_entries,
    output logic [TBL_IDX_W-1:0]  tbl_idx,
    input  logic [DRP_ADDR_W-1:0] tbl_addr,
    input  logic [DRP_DATA_W-1:0] tbl_mask,
    input  logic [DRP_DATA_W-1:0] tbl_data,
    mmcm_drp_reconfig_if.master   drp,
    output logic                  mmcm_rst,
    input  logic                  mmcm_locked,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);

    state_e                state_q, state_d;
    logic [TBL_IDX_W-1:0]  num_q, num_d;
    logic [TBL_IDX_W-1:0]  idx_q, idx_d;
    logic [DRP_DATA_W-1:0] di_q, di_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic                  mmcm_rst_q, mmcm_rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  lock_meta_q, lock_meta_d;
    logic                  lock_sync_q, lock_sync_d;

    drp_entry_t            entry;
    logic                  acc_req, acc_we, acc_ack, acc_timeout;
    logic [DRP_DATA_W-1:0] acc_rdata;

    assign entry    = '{addr: tbl_addr, mask: tbl_mask, data: tbl_data};
    assign tbl_idx  = idx_q;
    assign mmcm_rst = mmcm_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

    drp_access #(
        .DRDY_TIMEOUT(DRDY_TIMEOUT)
    ) u_access (
        .clk    (clk),
        .rst    (rst),
        .req    (acc_req),
        .we     (acc_we),
        .addr   (entry.addr),
        .wdata  (di_q),
        .drp    (drp),
        .rdata  (acc_rdata),
        .ack    (acc_ack),
        .timeout(acc_timeout)
    );

    // A fault leaves mmcm_rst where it was, so a DRDY fault keeps the MMCM held.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        idx_d       = idx_q;
        di_d        = di_q;
        hold_cnt_d  = hold_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        mmcm_rst_d  = mmcm_rst_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        lock_meta_d = mmcm_locked;
        lock_sync_d = lock_meta_q;
        acc_req     = 1'b0;
        acc_we      = 1'b0;

        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (start) begin
                    state_d    = ST_ASSERT_RST;
                    num_d      = num_entries;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    mmcm_rst_d = 1'b1;
                end
            end
            ST_ASSERT_RST: begin
                hold_cnt_d = '0;
                state_d    = (num_q == '0) ? ST_HOLD : ST_RD_REQ;
            end
            ST_RD_REQ: begin
                acc_req = 1'b1;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (acc_ack) begin
                    di_d    = drp_merge(entry, acc_rdata);
                    state_d = ST_WR_REQ;
                end else if (acc_timeout) begin
                    state_d = ST_FAULT;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            end
            ST_WR_REQ: begin
                acc_req = 1'b1;
                acc_we  = 1'b1;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (acc_ack) begin
`ifdef MMCM_DRP_VERIFY_EN
                    state_d = ST_VFY_REQ;
`else
                    state_d = ST_NEXT;
`endif
                end else if (acc_timeout) begin
                    state_d = ST_FAULT;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            end
`ifdef MMCM_DRP_VERIFY_EN
            ST_VFY_REQ: begin
                acc_req = 1'b1;
                state_d = ST_VFY_WAIT;
            end
            ST_VFY_WAIT: begin
                if (acc_ack && (acc_rdata == di_q)) begin
                    state_d = ST_NEXT;
                end else if (acc_ack || acc_timeout) begin
                    state_d = ST_FAULT;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            end
`endif
            ST_NEXT: begin
                idx_d = idx_q + TBL_IDX_W'(1);
                if (({1'b0, idx_q} + (TBL_IDX_W+1)'(1)) < {1'b0, num_q}) begin
                    state_d = ST_RD_REQ;
                end else begin
                    hold_cnt_d = '0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
                    mmcm_rst_d = 1'b0;
                    lock_cnt_d = '0;
                    state_d    = ST_WAIT_LOCK;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (lock_cnt_q == LOCK_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = ST_FAULT;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            idx_q       <= '0;
            di_q        <= '0;
            hold_cnt_q  <= '0;
            lock_cnt_q  <= '0;
            mmcm_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            di_q        <= di_d;
            hold_cnt_q  <= hold_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            mmcm_rst_q  <= mmcm_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
        end
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig with a behavioural DRP slave and MMCM
// lock model; expectations follow MMCM_DRP_VERIFY_EN when it is defined.
module tb_mmcm_drp_reconfig;
    import mmcm_drp_pkg::*;

    localparam int LOCK_TO = 256;
`ifdef MMCM_DRP_VERIFY_EN
    localparam int VFY = 1;
`else
    localparam int VFY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start;
    logic [4:0]  num_entries, tbl_idx;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_mask, tbl_data;
    logic        mmcm_rst, mmcm_locked, busy, done, error;

    mmcm_drp_reconfig_if drp ();

    mmcm_drp_reconfig #(
        .DRDY_TIMEOUT(64),
        .RST_HOLD    (8),
        .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_entries(num_entries),
        .tbl_idx    (tbl_idx),
        .tbl_addr   (tbl_addr),
        .tbl_mask   (tbl_mask),
        .tbl_data   (tbl_data),
        .drp        (drp.master),
        .mmcm_rst   (mmcm_rst),
        .mmcm_locked(mmcm_locked),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [6:0]  t_addr [32];
    logic [15:0] t_mask [32];
    logic [15:0] t_data [32];

    always_comb begin
        tbl_addr = t_addr[tbl_idx];
        tbl_mask = t_mask[tbl_idx];
        tbl_data = t_data[tbl_idx];
    end

    // DRP slave: registers default to 0xFFFF, answers two cycles after DEN.
    logic [15:0] mem [128];
    bit          written [128];
    logic [6:0]  wr_addr [8];
    logic [15:0] wr_data [8];
    logic [6:0]  rd_addr [8];
    logic [15:0] resp;
    int          den_count, wr_cnt, rd_cnt, rst_viol, dwe_viol, lat;
    bit          model_clr = 1'b0, no_drdy = 1'b0, corrupt = 1'b0;

    always @(negedge clk) begin
        if (model_clr) begin
            den_count = 0; wr_cnt = 0; rd_cnt = 0; rst_viol = 0; dwe_viol = 0; lat = 0;
            drp.drp_drdy = 1'b0;
            drp.drp_do   = 16'h0000;
            for (int i = 0; i < 128; i++) begin
                mem[i]     = 16'hFFFF;
                written[i] = 1'b0;
            end
        end else begin
            drp.drp_drdy = 1'b0;
            if (lat != 0) begin
                lat--;
                if (lat == 0 && !no_drdy) begin
                    drp.drp_drdy = 1'b1;
                    drp.drp_do   = resp;
                end
            end
            if (drp.drp_dwe && !drp.drp_den) dwe_viol++;
            if (drp.drp_den) begin
                den_count++;
                if (mmcm_rst !== 1'b1) rst_viol++;
                if (drp.drp_dwe) begin
                    if (wr_cnt < 8) begin
                        wr_addr[wr_cnt] = drp.drp_daddr;
                        wr_data[wr_cnt] = drp.drp_di;
                    end
                    wr_cnt++;
                    mem[drp.drp_daddr]     = drp.drp_di;
                    written[drp.drp_daddr] = 1'b1;
                    resp = 16'h0000;
                end else begin
                    if (rd_cnt < 8) rd_addr[rd_cnt] = drp.drp_daddr;
                    rd_cnt++;
                    resp = mem[drp.drp_daddr] ^ ((corrupt && written[drp.drp_daddr]) ? 16'h0001 : 16'h0000);
                end
                lat = 2;
            end
        end
    end

    // MMCM lock model: LOCKED rises 20 cycles after RST falls when enabled.
    bit lock_en = 1'b1;
    int rel_cnt = 0;

    always @(negedge clk) begin
        if (mmcm_rst !== 1'b0) begin
            mmcm_locked = 1'b0;
            rel_cnt     = 0;
        end else if (lock_en) begin
            rel_cnt++;
            if (rel_cnt >= 20) mmcm_locked = 1'b1;
        end else begin
            mmcm_locked = 1'b0;
        end
    end

    task automatic clear_model();
        model_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] n);
        @(negedge clk);
        num_entries = n;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic set_entry(input int i, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        t_addr[i] = a;
        t_mask[i] = m;
        t_data[i] = d;
    endtask

    task automatic wait_not_busy(input int budget, input string name);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s_finish: busy=%b after %0d cycles, required 0", name, busy, k);
        end
    endtask

    task automatic test_reset();
        logic [33:0] outs;
        int k;
        n_cmp++;
        if ({busy, mmcm_rst, done, error, drp.drp_den} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL por_outputs: got %b required 00000", {busy, mmcm_rst, done, error, drp.drp_den});
        end
        @(negedge clk);
        rst = 1'b0;
        set_entry(0, 7'h08, 16'h1000, 16'h0145);
        set_entry(1, 7'h09, 16'h8000, 16'h0000);
        clear_model();
        pulse_start(5'd2);
        k = 0;
        while (tbl_idx != 5'd1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if ({busy, mmcm_rst} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL midrun_pre: busy,mmcm_rst=%b required 11", {busy, mmcm_rst});
        end
        #1 rst = 1'b1;
        #1;
        outs = {busy, mmcm_rst, done, error, drp.drp_den, drp.drp_dwe, tbl_idx, drp.drp_daddr, drp.drp_di};
        n_cmp++;
        if (outs !== 34'h0) begin
            n_fail++;
            $display("[TB] FAIL midrun_reset: outputs=%h required 0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        k = den_count;
        repeat (100) @(negedge clk);
        n_cmp++;
        if (den_count !== k) begin
            n_fail++;
            $display("[TB] FAIL idle_den: %0d DEN pulses while idle, required 0", den_count - k);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_two_entries();
        set_entry(0, 7'h08, 16'h1000, 16'h0145);
        set_entry(1, 7'h09, 16'h8000, 16'h0000);
        lock_en = 1'b1; no_drdy = 1'b0; corrupt = 1'b0;
        clear_model();
        pulse_start(5'd2);
        wait_not_busy(500, "two_entries");
        n_cmp++;
        if (den_count !== 4 + 2 * VFY) begin
            n_fail++;
            $display("[TB] FAIL two_den_count: got %0d required %0d", den_count, 4 + 2 * VFY);
        end
        n_cmp++;
        if (wr_cnt !== 2 || wr_addr[0] !== 7'h08 || wr_data[0] !== 16'h1145) begin
            n_fail++;
            $display("[TB] FAIL two_write0: cnt=%0d addr=%h di=%h required 2/08/1145", wr_cnt, wr_addr[0], wr_data[0]);
        end
        n_cmp++;
        if (wr_addr[1] !== 7'h09 || wr_data[1] !== 16'h8000) begin
            n_fail++;
            $display("[TB] FAIL two_write1: addr=%h di=%h required 09/8000", wr_addr[1], wr_data[1]);
        end
        n_cmp++;
        if (rd_addr[0] !== 7'h08) begin
            n_fail++;
            $display("[TB] FAIL two_read0_addr: got %h required 08", rd_addr[0]);
        end
        n_cmp++;
        if (rst_viol !== 0 || dwe_viol !== 0) begin
            n_fail++;
            $display("[TB] FAIL two_protocol: den_outside_rst=%0d dwe_without_den=%0d required 0/0", rst_viol, dwe_viol);
        end
        n_cmp++;
        if ({done, error, tbl_idx} !== {1'b1, 1'b0, 5'd2}) begin
            n_fail++;
            $display("[TB] FAIL two_status: done=%b error=%b idx=%0d required 1/0/2", done, error, tbl_idx);
        end
    endtask

    task automatic test_zero_entries();
        int hi;
        lock_en = 1'b1;
        clear_model();
        pulse_start(5'd0);
        hi = (mmcm_rst === 1'b1) ? 1 : 0;
        for (int i = 0; i < 300 && busy; i++) begin
            if (i == 3) begin
                start       = 1'b1;
                num_entries = 5'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (mmcm_rst === 1'b1) hi++;
        end
        start = 1'b0;
        n_cmp++;
        if (hi !== 9) begin
            n_fail++;
            $display("[TB] FAIL zero_rst_width: mmcm_rst high %0d cycles, required 9", hi);
        end
        n_cmp++;
        if (den_count !== 0) begin
            n_fail++;
            $display("[TB] FAIL zero_den: got %0d required 0", den_count);
        end
        n_cmp++;
        if ({busy, done, error, tbl_idx} !== {1'b0, 1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("[TB] FAIL zero_status: busy=%b done=%b error=%b idx=%0d required 0/1/0/0", busy, done, error, tbl_idx);
        end
    endtask

    task automatic test_drdy_timeout();
        int k;
        set_entry(0, 7'h08, 16'h1000, 16'h0145);
        no_drdy = 1'b1;
        clear_model();
        pulse_start(5'd1);
        k = 0;
        while (!drp.drp_den && k < 20) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (!error && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k !== 65) begin
            n_fail++;
            $display("[TB] FAIL drdy_to_latency: error seen %0d cycles after DEN cycle, required 65", k);
        end
        n_cmp++;
        if ({error, busy, done, mmcm_rst} !== 4'b1001) begin
            n_fail++;
            $display("[TB] FAIL drdy_to_status: error,busy,done,mmcm_rst=%b required 1001", {error, busy, done, mmcm_rst});
        end
        n_cmp++;
        if (den_count !== 1) begin
            n_fail++;
            $display("[TB] FAIL drdy_to_den: got %0d required 1", den_count);
        end
        no_drdy = 1'b0;
        clear_model();
        pulse_start(5'd1);
        n_cmp++;
        if ({error, busy} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL restart_clears: error,busy=%b required 01", {error, busy});
        end
        wait_not_busy(500, "restart");
    endtask

    task automatic test_lock_timeout();
        int k;
        lock_en = 1'b0;
        clear_model();
        pulse_start(5'd0);
        k = 0;
        while (mmcm_rst && k < 50) begin
            @(negedge clk);
            k++;
        end
        k = 1;
        while (!error && k < 600) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k !== LOCK_TO + 1) begin
            n_fail++;
            $display("[TB] FAIL lock_to_latency: error seen in cycle %0d of lock wait, required %0d", k, LOCK_TO + 1);
        end
        n_cmp++;
        if ({error, mmcm_rst, done, busy} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL lock_to_status: error,mmcm_rst,done,busy=%b required 1000", {error, mmcm_rst, done, busy});
        end
    endtask

    task automatic test_verify();
        set_entry(0, 7'h0A, 16'hFF00, 16'h0033);
        lock_en = 1'b1; corrupt = 1'b1;
        clear_model();
        pulse_start(5'd1);
        wait_not_busy(500, "verify");
        corrupt = 1'b0;
        n_cmp++;
        if (wr_data[0] !== 16'hFF33) begin
            n_fail++;
            $display("[TB] FAIL verify_wdata: got %h required FF33", wr_data[0]);
        end
        n_cmp++;
        if (den_count !== 2 + VFY) begin
            n_fail++;
            $display("[TB] FAIL verify_den: got %0d required %0d", den_count, 2 + VFY);
        end
        n_cmp++;
        if ({error, done} !== ((VFY != 0) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("[TB] FAIL verify_status: error,done=%b required %b", {error, done}, (VFY != 0) ? 2'b10 : 2'b01);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_entries = 5'd0;
        for (int i = 0; i < 32; i++) set_entry(i, 7'h00, 16'hFFFF, 16'h0000);
        repeat (3) @(negedge clk);
        $display("[TB] reset");
        test_reset();
        $display("[TB] two entries");
        test_two_entries();
        $display("[TB] zero entries");
        test_zero_entries();
        $display("[TB] drdy timeout");
        test_drdy_timeout();
        $display("[TB] lock timeout");
        test_lock_timeout();
        $display("[TB] verify");
        test_verify();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
